// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the SD CMD-line sequencer:
//   - state_t    : sequencer FSM state encoding
//   - CMD_W      : width of the command frame sent to the physical layer
//   - RESP_W     : width of the response returned by the physical layer
//   - START_BIT  : value of the frame start bit
//   - TX_BIT     : value of the frame transmission bit (host -> card)
//   - build_frame: assembles {start, transmission, index, argument}
// -----------------------------------------------------------------------------
package cmd_pkg;

  localparam int   CMD_W     = 40;
  localparam int   RESP_W    = 15;
  localparam int   IDX_W     = 6;
  localparam int   ARG_W     = 32;
  localparam logic START_BIT = 1'b0;
  localparam logic TX_BIT    = 1'b1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND      = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_RESP = 3'd3,
    RESP_ACK  = 3'd4,
    DONE      = 3'd5
  } state_t;

  // The physical layer appends CRC and end bit itself; the sequencer only
  // supplies the leading 40 bits.
  function automatic logic [CMD_W-1:0] build_frame(
    input logic [IDX_W-1:0] index,
    input logic [ARG_W-1:0] argument
  );
    return {START_BIT, TX_BIT, index, argument};
  endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// -----------------------------------------------------------------------------
// cmd_watchdog
// Per-state cycle counter for the command sequencer. The count restarts on
// the first cycle of every state and only advances while enabled (wait
// states). expire is a combinational pulse, high in the cycle whose edge
// takes the count to WATCHDOG_CYCLES-1, so the owner can leave the state
// on that same edge.
//
// Ports:
//   sd_clock  in   clock, rising edge
//   reset     in   synchronous, active-high
//   restart   in   first cycle of a new state: count treated as zero
//   enable    in   count this cycle (sequencer is in a wait state)
//   expire    out  budget used up; abort on this edge
// -----------------------------------------------------------------------------
module cmd_watchdog #(
  parameter int WATCHDOG_CYCLES = 1024,
  parameter int WD_W            = 11
) (
  input  logic sd_clock,
  input  logic reset,
  input  logic restart,
  input  logic enable,
  output logic expire
);

  logic [WD_W-1:0] count;
  logic [WD_W-1:0] count_cur;

  // A restart overrides whatever was left from the previous state so the
  // first cycle of each state always sees a zero count.
  assign count_cur = restart ? '0 : count;

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      count <= '0;
    end else if (enable) begin
      count <= count_cur + WD_W'(1);
    end else begin
      count <= '0;
    end
  end

  // Fires on the edge where the count advances to WATCHDOG_CYCLES-1, which
  // puts the forced completion exactly WATCHDOG_CYCLES edges after entry.
  assign expire = enable && (count_cur == WD_W'(WATCHDOG_CYCLES - 2));

endmodule

// File: rtl/cmd_sequencer.sv
// -----------------------------------------------------------------------------
// cmd_sequencer
// Command-level controller for the SD CMD physical layer. Latches a host
// command, builds the 40-bit frame, runs the strobe/ack handshake with the
// physical layer, collects the response (or timeout), retries on timeout and
// reports completion. A watchdog bounds every wait state.
//
// Ports:
//   sd_clock       in   clock, rising edge
//   reset          in   synchronous, active-high
//   new_command    in   host request pulse, sampled only in IDLE
//   cmd_index      in   [5:0]  command index
//   cmd_argument   in   [31:0] command argument
//   no_response    in   command expects no response
//   cmd_busy       out  acceptance .. cmd_done
//   cmd_done       out  one-cycle completion pulse
//   cmd_response   out  [14:0] last response (valid with cmd_done, no error)
//   cmd_error      out  retries exhausted or watchdog abort
//   retry_count    out  [1:0] retries used by the current/last command
//   phy_strobe     out  command valid to the physical layer
//   phy_ack        out  response consumed
//   phy_idle       out  sequencer idle
//   phy_cmd        out  [39:0] command frame
//   phy_ack_in     in   physical layer accepted the command
//   phy_strobe_in  in   response or timeout ready
//   phy_response   in   [14:0] response bits
//   phy_timeout    in   command timeout, qualified by phy_strobe_in
// -----------------------------------------------------------------------------
module cmd_sequencer
  import cmd_pkg::*;
#(
  parameter int MAX_RETRIES     = 2,
  parameter int WATCHDOG_CYCLES = 1024,
  parameter int WD_W            = 11
) (
  input  logic              sd_clock,
  input  logic              reset,
  input  logic              new_command,
  input  logic [IDX_W-1:0]  cmd_index,
  input  logic [ARG_W-1:0]  cmd_argument,
  input  logic              no_response,
  output logic              cmd_busy,
  output logic              cmd_done,
  output logic [RESP_W-1:0] cmd_response,
  output logic              cmd_error,
  output logic [1:0]        retry_count,
  output logic              phy_strobe,
  output logic              phy_ack,
  output logic              phy_idle,
  output logic [CMD_W-1:0]  phy_cmd,
  input  logic              phy_ack_in,
  input  logic              phy_strobe_in,
  input  logic [RESP_W-1:0] phy_response,
  input  logic              phy_timeout
);

  state_t state;
  state_t state_prev;
  state_t after_ack;     // where RESP_ACK goes once the handshake closes
  logic   no_resp_q;
  logic   err_pend;      // error decided earlier, published at DONE

  logic   wd_restart;
  logic   wd_enable;
  logic   wd_expire;

  // The watchdog budget is per state: a change of state restarts it.
  assign wd_restart = (state != state_prev);
  assign wd_enable  = (state == WAIT_ACK) || (state == WAIT_RESP) ||
                      (state == RESP_ACK);

  cmd_watchdog #(
    .WATCHDOG_CYCLES (WATCHDOG_CYCLES),
    .WD_W            (WD_W)
  ) u_watchdog (
    .sd_clock (sd_clock),
    .reset    (reset),
    .restart  (wd_restart),
    .enable   (wd_enable),
    .expire   (wd_expire)
  );

  always_ff @(posedge sd_clock) begin
    if (reset) begin
      state        <= IDLE;
      state_prev   <= IDLE;
      after_ack    <= IDLE;
      no_resp_q    <= 1'b0;
      err_pend     <= 1'b0;
      cmd_busy     <= 1'b0;
      cmd_done     <= 1'b0;
      cmd_response <= '0;
      cmd_error    <= 1'b0;
      retry_count  <= 2'd0;
      phy_strobe   <= 1'b0;
      phy_ack      <= 1'b0;
      phy_idle     <= 1'b1;
      phy_cmd      <= '0;
    end else begin
      state_prev <= state;
      cmd_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (new_command) begin
            phy_cmd      <= build_frame(cmd_index, cmd_argument);
            no_resp_q    <= no_response;
            retry_count  <= 2'd0;
            cmd_response <= '0;
            cmd_error    <= 1'b0;
            err_pend     <= 1'b0;
            cmd_busy     <= 1'b1;
            phy_idle     <= 1'b0;
            state        <= SEND;
          end else begin
            // Covers the cmd_done cycle: busy falls right after the pulse.
            cmd_busy <= 1'b0;
          end
        end

        SEND: begin
          phy_strobe <= 1'b1;
          state      <= WAIT_ACK;
        end

        // A response strobe arriving here is deliberately not looked at;
        // it is picked up once WAIT_RESP is entered.
        WAIT_ACK: begin
          if (wd_expire) begin
            phy_strobe <= 1'b0;
            err_pend   <= 1'b1;
            state      <= DONE;
          end else if (phy_ack_in) begin
            phy_strobe <= 1'b0;
            state      <= no_resp_q ? DONE : WAIT_RESP;
          end
        end

        WAIT_RESP: begin
          if (wd_expire) begin
            err_pend <= 1'b1;
            state    <= DONE;
          end else if (phy_strobe_in) begin
            phy_ack <= 1'b1;
            state   <= RESP_ACK;
            if (!phy_timeout) begin
              cmd_response <= phy_response;
              after_ack    <= DONE;
            end else if (retry_count < 2'(MAX_RETRIES)) begin
              retry_count <= retry_count + 2'd1;
              after_ack   <= SEND;
            end else begin
              err_pend  <= 1'b1;
              after_ack <= DONE;
            end
          end
        end

        // Four-phase close: hold ack until the physical layer drops its
        // strobe, then take the path chosen in WAIT_RESP.
        RESP_ACK: begin
          if (wd_expire) begin
            phy_ack  <= 1'b0;
            err_pend <= 1'b1;
            state    <= DONE;
          end else if (!phy_strobe_in) begin
            phy_ack <= 1'b0;
            state   <= after_ack;
          end
        end

        DONE: begin
          cmd_done  <= 1'b1;
          cmd_error <= err_pend;
          phy_idle  <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          phy_strobe <= 1'b0;
          phy_ack    <= 1'b0;
          phy_idle   <= 1'b1;
          cmd_busy   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cmd_sequencer
// Self-checking bench: a cycle-stepped physical-layer model answers the
// sequencer; per-command outcomes are predicted from the command rules
// (retry budget, no-response, watchdog) and compared through chk().
// -----------------------------------------------------------------------------
module tb_cmd_sequencer;

  localparam int MAX_RETRIES     = 2;
  localparam int WATCHDOG_CYCLES = 64;
  localparam int WD_W            = 7;

  logic        sd_clock = 1'b0;
  logic        reset;
  logic        new_command;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_argument;
  logic        no_response;
  logic        cmd_busy;
  logic        cmd_done;
  logic [14:0] cmd_response;
  logic        cmd_error;
  logic [1:0]  retry_count;
  logic        phy_strobe;
  logic        phy_ack;
  logic        phy_idle;
  logic [39:0] phy_cmd;
  logic        phy_ack_in;
  logic        phy_strobe_in;
  logic [14:0] phy_response;
  logic        phy_timeout;

  cmd_sequencer #(
    .MAX_RETRIES     (MAX_RETRIES),
    .WATCHDOG_CYCLES (WATCHDOG_CYCLES),
    .WD_W            (WD_W)
  ) dut (
    .sd_clock      (sd_clock),
    .reset         (reset),
    .new_command   (new_command),
    .cmd_index     (cmd_index),
    .cmd_argument  (cmd_argument),
    .no_response   (no_response),
    .cmd_busy      (cmd_busy),
    .cmd_done      (cmd_done),
    .cmd_response  (cmd_response),
    .cmd_error     (cmd_error),
    .retry_count   (retry_count),
    .phy_strobe    (phy_strobe),
    .phy_ack       (phy_ack),
    .phy_idle      (phy_idle),
    .phy_cmd       (phy_cmd),
    .phy_ack_in    (phy_ack_in),
    .phy_strobe_in (phy_strobe_in),
    .phy_response  (phy_response),
    .phy_timeout   (phy_timeout)
  );

  always #5 sd_clock = ~sd_clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [39:0] last_first_cmd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge sd_clock);
    #1;
    cyc++;
  endtask

  // Issue one command and play the physical layer until cmd_done.
  //   ack_dly   : extra cycles of strobe before the phy acks
  //   ack_never : phy never acks (watchdog path)
  //   n_to      : number of leading attempts answered with a timeout
  //   resp_dly  : cycles between command ack and response strobe
  //   poke      : pulse new_command while busy (must be ignored)
  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic nr,
                         input int ack_dly, input bit ack_never, input int n_to,
                         input logic [14:0] resp, input int resp_dly, input bit poke);
    logic [39:0] frame;
    logic [39:0] first_cmd;
    int  c0, rel, hi, attempt, rphase, rwait;
    int  strobes, dones, first_strobe, ack_cyc, done_cyc;
    int  exp_retry, exp_strobes;
    bit  exp_err, frame_ok, busy_ok;
    logic [14:0] exp_resp;
    logic got_err;
    logic [1:0] got_retry;
    logic [14:0] got_resp;

    frame = {1'b0, 1'b1, idx, arg};
    // Expected outcome straight from the command rules.
    if (ack_never) begin
      exp_err = 1'b1; exp_retry = 0; exp_resp = '0; exp_strobes = 1;
    end else if (nr) begin
      exp_err = 1'b0; exp_retry = 0; exp_resp = '0; exp_strobes = 1;
    end else begin
      exp_retry   = (n_to > MAX_RETRIES) ? MAX_RETRIES : n_to;
      exp_err     = (n_to > MAX_RETRIES);
      exp_resp    = exp_err ? 15'd0 : resp;
      exp_strobes = exp_retry + 1;
    end

    first_cmd = '0; hi = 0; attempt = 0; rphase = 0; rwait = 0;
    strobes = 0; dones = 0; first_strobe = -1; ack_cyc = -1; done_cyc = -1;
    frame_ok = 1'b1; busy_ok = 1'b1;
    got_err = 1'b0; got_retry = '0; got_resp = '0;

    c0 = cyc;
    new_command  = 1'b1;
    cmd_index    = idx;
    cmd_argument = arg;
    no_response  = nr;

    for (int k = 0; k < 400 && dones == 0; k++) begin
      step();
      rel = cyc - c0;
      if (k == 0) begin
        // Inputs must already be latched; scramble them.
        cmd_index    = 6'($urandom);
        cmd_argument = $urandom;
        no_response  = 1'($urandom);
      end
      // Observe this cycle.
      if (phy_strobe && hi == 0) begin
        strobes++;
        if (first_strobe < 0) begin
          first_strobe = rel;
          first_cmd    = phy_cmd;
        end
        if (phy_cmd !== frame) frame_ok = 1'b0;
      end
      if (!cmd_busy) busy_ok = 1'b0;
      if (cmd_done) begin
        dones++;
        done_cyc  = rel;
        got_err   = cmd_error;
        got_retry = retry_count;
        got_resp  = cmd_response;
      end else begin
        new_command = (poke && rel >= 3 && rel <= 20) ? 1'($urandom) : 1'b0;
        // Response side of the phy model.
        case (rphase)
          1: begin
            if (rwait == 0) begin
              phy_strobe_in = 1'b1;
              phy_timeout   = (attempt < n_to);
              phy_response  = (attempt < n_to) ? 15'($urandom) : resp;
              rphase = 2;
            end else begin
              rwait--;
            end
          end
          2: if (phy_ack) begin
            phy_strobe_in = 1'b0;
            phy_timeout   = 1'b0;
            attempt++;
            rphase = 3;
          end
          3: if (!phy_ack) rphase = 0;
          default: ;
        endcase
        // Command side of the phy model.
        if (phy_strobe) begin
          hi++;
          phy_ack_in = !ack_never && (hi > ack_dly);
          if (phy_ack_in) begin
            ack_cyc = rel;
            if (!nr) begin
              rphase = 1;
              rwait  = resp_dly;
            end
          end
        end else begin
          hi = 0;
          phy_ack_in = 1'b0;
        end
      end
    end
    new_command   = 1'b0;
    phy_ack_in    = 1'b0;
    phy_strobe_in = 1'b0;
    phy_timeout   = 1'b0;
    last_first_cmd = first_cmd;

    chk("done_seen", dones, 1);
    chk("phy_cmd", first_cmd, frame);
    chk("frame_stable", frame_ok, 1);
    chk("busy_during", busy_ok, 1);
    chk("strobe_count", strobes, exp_strobes);
    chk("strobe_latency", first_strobe, 2);
    chk("cmd_error", got_err, exp_err);
    chk("retry_count", got_retry, exp_retry);
    chk("cmd_response", got_resp, exp_resp);
    if (ack_never)
      chk("watchdog_latency", done_cyc - first_strobe, WATCHDOG_CYCLES);
    else if (nr)
      chk("nr_latency", done_cyc - ack_cyc, 2);

    step();
    chk("busy_after", cmd_busy, 0);
    chk("done_pulse", cmd_done, 0);
    chk("idle_after", phy_idle, 1);
    chk("resp_hold", cmd_response, exp_resp);
    chk("err_hold", cmd_error, exp_err);
    if (poke) begin
      for (int j = 0; j < 3; j++) begin
        step();
        chk("no_spurious_send", phy_strobe, 0);
      end
    end
  endtask

  initial begin
    reset = 1'b1; new_command = 1'b0; cmd_index = '0; cmd_argument = '0;
    no_response = 1'b0; phy_ack_in = 1'b0; phy_strobe_in = 1'b0;
    phy_response = '0; phy_timeout = 1'b0;
    step(); step();
    chk("rst_idle", phy_idle, 1);
    chk("rst_strobe", phy_strobe, 0);
    chk("rst_busy", cmd_busy, 0);
    chk("rst_done", cmd_done, 0);
    chk("rst_cmd", phy_cmd, 0);
    chk("rst_retry", retry_count, 0);
    reset = 1'b0;
    step();

    // Reset while waiting for a response.
    new_command = 1'b1; cmd_index = 6'd5; cmd_argument = 32'hDEAD_BEEF; no_response = 1'b0;
    step();
    new_command = 1'b0;
    for (int k = 0; k < 10 && !phy_strobe; k++) step();
    chk("mid_strobe_seen", phy_strobe, 1);
    phy_ack_in = 1'b1;
    step();
    phy_ack_in = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_idle", phy_idle, 1);
    chk("midrst_strobe", phy_strobe, 0);
    chk("midrst_busy", cmd_busy, 0);
    chk("midrst_ack", phy_ack, 0);
    begin
      int pulses = 0;
      for (int k = 0; k < 5; k++) begin
        step();
        if (cmd_done || cmd_busy) pulses++;
      end
      chk("midrst_quiet", pulses, 0);
    end

    // Directed cases.
    run_cmd(6'd8, 32'h0000_01AA, 1'b0, 3, 1'b0, 0, 15'h1A5, 2, 1'b0);
    chk("phy_cmd_cmd8", last_first_cmd, 40'h48_0000_01AA);
    run_cmd(6'd0, 32'h0, 1'b1, 0, 1'b0, 0, 15'h0, 0, 1'b0);
    chk("phy_cmd_cmd0", last_first_cmd, 40'h40_0000_0000);
    run_cmd(6'd17, 32'h1234_5678, 1'b0, 1, 1'b0, 2, 15'h0123, 1, 1'b0);
    run_cmd(6'd55, 32'hCAFE_0001, 1'b0, 0, 1'b0, 3, 15'h7FFF, 0, 1'b0);
    run_cmd(6'd2, 32'h0F0F_F0F0, 1'b0, 0, 1'b1, 0, 15'h0, 0, 1'b1);

    // Randomized commands.
    for (int n = 0; n < 40; n++) begin
      int gap;
      run_cmd(6'($urandom), $urandom, ($urandom_range(0, 3) == 0),
              $urandom_range(0, 4), 1'b0, $urandom_range(0, 3),
              15'($urandom), $urandom_range(0, 5), 1'b0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
